// File: rtl/led_pattern_seq.sv
// led_pattern_seq: per-LED programmable step-pattern player with PWM brightness.
// Consumes the 1-cycle timebase tick and a valid/ready config port. Each LED holds
// a PAT_LEN-bit on/off pattern, a ticks-per-step rate and a PWM duty value.
// Optional feature: define LED_PATTERN_ONESHOT_EN to add the cfg_oneshot input and
// the done output; a one-shot LED stops on its last step instead of looping.
module led_pattern_seq #(
  parameter int NUM_LED  = 2,
  parameter int PAT_LEN  = 8,
  parameter int PWM_BITS = 4,
  parameter int STEP_W   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick_in,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_led,
  input  logic [PAT_LEN-1:0]  cfg_pattern,
  input  logic [STEP_W-1:0]   cfg_step_ticks,
  input  logic [PWM_BITS-1:0] cfg_duty,
`ifdef LED_PATTERN_ONESHOT_EN
  input  logic                cfg_oneshot,
  output logic [NUM_LED-1:0]  done,
`endif
  output logic                cfg_err,
  output logic [NUM_LED-1:0]  ledout
);

  // Step index width; PAT_LEN is a power of two so the index covers it exactly.
  localparam int SW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [SW-1:0]       STEP_LAST = SW'(PAT_LEN - 1);
  localparam logic [SW-1:0]       STEP_ONE  = SW'(1);
  localparam logic [STEP_W-1:0]   TICK_ONE  = STEP_W'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);
  // One extra bit so that NUM_LED = 8 still compares correctly against a 3-bit index.
  localparam logic [3:0]          NUM_LED_W = 4'(NUM_LED);

  // Config FSM encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_APPLY = 1'b1;

  // Brightness gate: full duty is always on, otherwise on while the counter is below duty.
  function automatic logic on_pwm(input logic [PWM_BITS-1:0] duty,
                                  input logic [PWM_BITS-1:0] cnt);
    logic res;
    if (&duty) begin
      res = 1'b1;
    end else begin
      res = (cnt < duty);
    end
    return res;
  endfunction

  // Config FSM and holding register.
  logic [0:0]          state_q, state_d;
  logic [2:0]          hold_led_q, hold_led_d;
  logic [PAT_LEN-1:0]  hold_pattern_q, hold_pattern_d;
  logic [STEP_W-1:0]   hold_step_ticks_q, hold_step_ticks_d;
  logic [PWM_BITS-1:0] hold_duty_q, hold_duty_d;
  logic                hold_oneshot_q, hold_oneshot_d;
  logic                cfg_err_q, cfg_err_d;
  logic                apply_ok_s;

  // Per-LED state.
  logic [PAT_LEN-1:0]  pattern_q    [NUM_LED];
  logic [PAT_LEN-1:0]  pattern_d    [NUM_LED];
  logic [STEP_W-1:0]   step_ticks_q [NUM_LED];
  logic [STEP_W-1:0]   step_ticks_d [NUM_LED];
  logic [PWM_BITS-1:0] duty_q       [NUM_LED];
  logic [PWM_BITS-1:0] duty_d       [NUM_LED];
  logic [SW-1:0]       step_q       [NUM_LED];
  logic [SW-1:0]       step_d       [NUM_LED];
  logic [STEP_W-1:0]   tick_cnt_q   [NUM_LED];
  logic [STEP_W-1:0]   tick_cnt_d   [NUM_LED];
  logic [NUM_LED-1:0]  oneshot_q, oneshot_d;
  logic [NUM_LED-1:0]  done_q, done_d;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LED-1:0]  ledout_q, ledout_d;

`ifdef LED_PATTERN_ONESHOT_EN
  logic cfg_oneshot_s;
  assign cfg_oneshot_s = cfg_oneshot;
  assign done          = done_q;
`else
  logic cfg_oneshot_s;
  assign cfg_oneshot_s = 1'b0;
`endif

  // cfg_ready is a direct decode of the state flop, so it is glitch-free.
  assign cfg_ready = (state_q == ST_IDLE);
  assign cfg_err   = cfg_err_q;
  assign ledout    = ledout_q;

  // Config FSM: capture a request in IDLE, commit it to the target LED in APPLY.
  always_comb begin
    state_d           = state_q;
    hold_led_d        = hold_led_q;
    hold_pattern_d    = hold_pattern_q;
    hold_step_ticks_d = hold_step_ticks_q;
    hold_duty_d       = hold_duty_q;
    hold_oneshot_d    = hold_oneshot_q;
    cfg_err_d         = cfg_err_q;
    apply_ok_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          hold_led_d        = cfg_led;
          hold_pattern_d    = cfg_pattern;
          hold_step_ticks_d = cfg_step_ticks;
          hold_duty_d       = cfg_duty;
          hold_oneshot_d    = cfg_oneshot_s;
          state_d           = ST_APPLY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
        // Out-of-range target: leave every LED alone and flag the error.
        if ({1'b0, hold_led_q} >= NUM_LED_W) begin
          cfg_err_d = 1'b1;
        end else begin
          apply_ok_s = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Per-LED stepping; a config commit to an LED overrides that LED's tick.
  always_comb begin
    for (int i = 0; i < NUM_LED; i++) begin
      pattern_d[i]    = pattern_q[i];
      step_ticks_d[i] = step_ticks_q[i];
      duty_d[i]       = duty_q[i];
      step_d[i]       = step_q[i];
      tick_cnt_d[i]   = tick_cnt_q[i];
      oneshot_d[i]    = oneshot_q[i];
      done_d[i]       = done_q[i];
      if (apply_ok_s && (hold_led_q == 3'(i))) begin
        pattern_d[i]    = hold_pattern_q;
        step_ticks_d[i] = hold_step_ticks_q;
        duty_d[i]       = hold_duty_q;
        step_d[i]       = {SW{1'b0}};
        tick_cnt_d[i]   = {STEP_W{1'b0}};
        oneshot_d[i]    = hold_oneshot_q;
        done_d[i]       = 1'b0;
      end else if (tick_in && (step_ticks_q[i] != {STEP_W{1'b0}})) begin
        if (oneshot_q[i] && (step_q[i] == STEP_LAST)) begin
          // One-shot LED parked on its final step.
          step_d[i]     = step_q[i];
          tick_cnt_d[i] = tick_cnt_q[i];
        end else if (tick_cnt_q[i] == (step_ticks_q[i] - TICK_ONE)) begin
          tick_cnt_d[i] = {STEP_W{1'b0}};
          if (step_q[i] == STEP_LAST) begin
            step_d[i] = {SW{1'b0}};
          end else begin
            step_d[i] = step_q[i] + STEP_ONE;
          end
          // done rises on the same edge the one-shot LED lands on its last step.
          if (oneshot_q[i] && (step_q[i] == (STEP_LAST - STEP_ONE))) begin
            done_d[i] = 1'b1;
          end else begin
            done_d[i] = done_q[i];
          end
        end else begin
          tick_cnt_d[i] = tick_cnt_q[i] + TICK_ONE;
        end
      end else begin
        step_d[i]     = step_q[i];
        tick_cnt_d[i] = tick_cnt_q[i];
      end
    end
  end

  // Free-running PWM counter and the LED drive computed from current state.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    for (int i = 0; i < NUM_LED; i++) begin
      ledout_d[i] = pattern_q[i][step_q[i]] & on_pwm(duty_q[i], pwm_cnt_q);
    end
  end

  // State registers with synchronous active-low reset; reset drops any pending config.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      hold_led_q        <= 3'd0;
      hold_pattern_q    <= {PAT_LEN{1'b0}};
      hold_step_ticks_q <= {STEP_W{1'b0}};
      hold_duty_q       <= {PWM_BITS{1'b0}};
      hold_oneshot_q    <= 1'b0;
      cfg_err_q         <= 1'b0;
      pwm_cnt_q         <= {PWM_BITS{1'b0}};
      ledout_q          <= {NUM_LED{1'b0}};
      oneshot_q         <= {NUM_LED{1'b0}};
      done_q            <= {NUM_LED{1'b0}};
      for (int i = 0; i < NUM_LED; i++) begin
        pattern_q[i]    <= {PAT_LEN{1'b0}};
        step_ticks_q[i] <= {STEP_W{1'b0}};
        duty_q[i]       <= {PWM_BITS{1'b0}};
        step_q[i]       <= {SW{1'b0}};
        tick_cnt_q[i]   <= {STEP_W{1'b0}};
      end
    end else begin
      state_q           <= state_d;
      hold_led_q        <= hold_led_d;
      hold_pattern_q    <= hold_pattern_d;
      hold_step_ticks_q <= hold_step_ticks_d;
      hold_duty_q       <= hold_duty_d;
      hold_oneshot_q    <= hold_oneshot_d;
      cfg_err_q         <= cfg_err_d;
      pwm_cnt_q         <= pwm_cnt_d;
      ledout_q          <= ledout_d;
      oneshot_q         <= oneshot_d;
      done_q            <= done_d;
      for (int i = 0; i < NUM_LED; i++) begin
        pattern_q[i]    <= pattern_d[i];
        step_ticks_q[i] <= step_ticks_d[i];
        duty_q[i]       <= duty_d[i];
        step_q[i]       <= step_d[i];
        tick_cnt_q[i]   <= tick_cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq (default parameters: 2 LEDs, 8 steps,
// 4-bit PWM). Cycle-accurate vector table plus hand-written multi-cycle sequences.
module tb_led_pattern_seq;

  logic       clk;
  logic       reset_n;
  logic       tick_in;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_led;
  logic [7:0] cfg_pattern;
  logic [7:0] cfg_step_ticks;
  logic [3:0] cfg_duty;
  logic       cfg_err;
  logic [1:0] ledout;
`ifdef LED_PATTERN_ONESHOT_EN
  logic       cfg_oneshot;
  logic [1:0] done;
`endif

  int checks = 0;
  int errors = 0;

  led_pattern_seq dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tick_in        (tick_in),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_led        (cfg_led),
    .cfg_pattern    (cfg_pattern),
    .cfg_step_ticks (cfg_step_ticks),
    .cfg_duty       (cfg_duty),
`ifdef LED_PATTERN_ONESHOT_EN
    .cfg_oneshot    (cfg_oneshot),
    .done           (done),
`endif
    .cfg_err        (cfg_err),
    .ledout         (ledout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       valid;
    logic [2:0] led;
    logic [7:0] pat;
    logic [7:0] st;
    logic [3:0] duty;
    logic [1:0] exp_led;
    logic       exp_rdy;
    logic       exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic tick, input logic valid, input logic [2:0] led,
                     input logic [7:0] pat, input logic [7:0] st, input logic [3:0] duty,
                     input logic [1:0] exp_led, input logic exp_rdy, input logic exp_err);
    vec_t v;
    v.tick = tick; v.valid = valid; v.led = led; v.pat = pat; v.st = st; v.duty = duty;
    v.exp_led = exp_led; v.exp_rdy = exp_rdy; v.exp_err = exp_err;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: inputs set after this returns are seen at the next edge; outputs
  // read after it show the result of the edge just taken.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic cfg_write(input logic [2:0] led, input logic [7:0] pat,
                           input logic [7:0] st, input logic [3:0] duty);
    chk("ready_before_write", {31'd0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1; cfg_led = led; cfg_pattern = pat; cfg_step_ticks = st; cfg_duty = duty;
    cyc();
    cfg_valid = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [15:0] pat_exp;
    string nm;

    reset_n = 1'b0; tick_in = 1'b0; cfg_valid = 1'b0; cfg_led = 3'd0;
    cfg_pattern = 8'd0; cfg_step_ticks = 8'd0; cfg_duty = 4'd0;
`ifdef LED_PATTERN_ONESHOT_EN
    cfg_oneshot = 1'b0;
`endif

    // Reset held for 3 clocks with tick toggling.
    repeat (3) begin
      cyc();
      tick_in = ~tick_in;
    end
    tick_in = 1'b0;
    reset_n = 1'b1;
    cyc();
    chk("rst_ledout", {30'd0, ledout}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);

    // Handshake / latency: two back-to-back writes with cfg_valid held.
    add(1'b0, 1'b1, 3'd0, 8'hFF, 8'd0, 4'hF, 2'b00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd1, 8'hFF, 8'd0, 4'hF, 2'b00, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd1, 8'hFF, 8'd0, 4'hF, 2'b01, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b01, 1'b1, 1'b0);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b11, 1'b1, 1'b0);
    // Collision: APPLY to LED0 coincides with a tick; LED1 keeps stepping.
    add(1'b0, 1'b1, 3'd0, 8'h01, 8'd2, 4'hF, 2'b11, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b11, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd1, 8'h02, 8'd1, 4'hF, 2'b11, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b11, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b01, 1'b1, 1'b0);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b11, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd0, 8'h01, 8'd2, 4'hF, 2'b11, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b11, 1'b1, 1'b0);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b01, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b01, 1'b1, 1'b0);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b01, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b01, 1'b1, 1'b0);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b00, 1'b1, 1'b0);
    // Error: write to LED index 5 changes nothing and sets sticky cfg_err.
    add(1'b0, 1'b1, 3'd5, 8'hFF, 8'd0, 4'hF, 2'b00, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b00, 1'b1, 1'b1);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b00, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b00, 1'b1, 1'b1);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'd0, 4'h0, 2'b00, 1'b1, 1'b1);

    for (int r = 0; r < vq.size(); r++) begin
      tick_in = vq[r].tick; cfg_valid = vq[r].valid; cfg_led = vq[r].led;
      cfg_pattern = vq[r].pat; cfg_step_ticks = vq[r].st; cfg_duty = vq[r].duty;
      cyc();
      nm = $sformatf("vec%0d", r);
      chk({nm, "_ledout"}, {30'd0, ledout}, {30'd0, vq[r].exp_led});
      chk({nm, "_ready"}, {31'd0, cfg_ready}, {31'd0, vq[r].exp_rdy});
      chk({nm, "_err"}, {31'd0, cfg_err}, {31'd0, vq[r].exp_err});
    end
    tick_in = 1'b0; cfg_valid = 1'b0;

    // cfg_err stays set across a good write and clears only on reset.
    cfg_write(3'd0, 8'hFF, 8'd0, 4'hF);
    cyc();
    chk("err_sticky", {31'd0, cfg_err}, 32'd1);
    chk("good_after_err", {31'd0, ledout[0]}, 32'd1);
    do_reset();
    chk("err_cleared", {31'd0, cfg_err}, 32'd0);
    chk("led_cleared", {30'd0, ledout}, 32'd0);

    // Pattern stepping: 0000_0101, 2 ticks per step, tick every 10 clocks.
    cfg_write(3'd0, 8'h05, 8'd2, 4'hF);
    cyc(); cyc();
    pat_exp = 16'h0033;
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("pattern_tick%0d", k), {31'd0, ledout[0]}, {31'd0, pat_exp[k % 16]});
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
      repeat (9) cyc();
    end

    // PWM brightness on LED1: high for duty out of every 16 clocks.
    cfg_write(3'd1, 8'hFF, 8'd0, 4'd4);
    cyc(); cyc();
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      cnt += int'(ledout[1]);
      cyc();
    end
    chk("pwm_duty4", cnt, 32'd4);
    cfg_write(3'd1, 8'hFF, 8'd0, 4'd0);
    cyc(); cyc();
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      cnt += int'(ledout[1]);
      cyc();
    end
    chk("pwm_duty0", cnt, 32'd0);
    cfg_write(3'd1, 8'hFF, 8'd0, 4'hF);
    cyc(); cyc();
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      cnt += int'(ledout[1]);
      cyc();
    end
    chk("pwm_dutyF", cnt, 32'd16);

    // Reset during APPLY discards the pending write and clears LED state.
    cfg_valid = 1'b1; cfg_led = 3'd0; cfg_pattern = 8'hFF; cfg_step_ticks = 8'd0; cfg_duty = 4'hF;
    cyc();
    cfg_valid = 1'b0;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc(); cyc(); cyc();
    chk("midapply_ledout", {30'd0, ledout}, 32'd0);
    chk("midapply_ready", {31'd0, cfg_ready}, 32'd1);

`ifdef LED_PATTERN_ONESHOT_EN
    // One-shot LED0 holds on step 7; done rises as it lands there.
    cfg_oneshot = 1'b1;
    cfg_write(3'd0, 8'h80, 8'd1, 4'hF);
    cfg_oneshot = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
      cyc(); cyc();
      chk($sformatf("oneshot_done%0d", k), {31'd0, done[0]}, (k >= 7) ? 32'd1 : 32'd0);
      chk($sformatf("oneshot_led%0d", k), {31'd0, ledout[0]}, (k >= 7) ? 32'd1 : 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
